axis_sync_pkt_fifo: RTL and testbench

//  Single-clock AXI-Stream FIFO carrying all sideband fields.

---
 rtl/axis_fifo_pkg.sv | 50 +++++
 rtl/sync_fifo_ram.sv | 26 ++
 rtl/axis_sync_pkt_fifo.sv | 188 ++++++++++++++++++
 tb/tb_axis_sync_pkt_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared field layout and write-state encoding for the AXI-Stream FIFO.
// A beat is packed LSB-first in field order: tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
package axis_fifo_pkg;

    localparam int F_TDATA = 0;
    localparam int F_TSTRB = 1;
    localparam int F_TKEEP = 2;
    localparam int F_TLAST = 3;
    localparam int F_TID   = 4;
    localparam int F_TDEST = 5;
    localparam int F_TUSER = 6;
    localparam int F_NUM   = 7;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } wr_state_e;

    function automatic int field_width(input int field, input int data_w, input int keep_w,
                                       input int id_w, input int dest_w, input int user_w);
        int w;
        case (field)
            F_TDATA: w = data_w;
            F_TSTRB: w = keep_w;
            F_TKEEP: w = keep_w;
            F_TLAST: w = 1;
            F_TID:   w = id_w;
            F_TDEST: w = dest_w;
            F_TUSER: w = user_w;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic int field_off(input int field, input int data_w, input int keep_w,
                                     input int id_w, input int dest_w, input int user_w);
        int off;
        off = 0;
        for (int f = 0; f < field; f++) begin
            off += field_width(f, data_w, keep_w, id_w, dest_w, user_w);
        end
        return off;
    endfunction

    function automatic int packed_width(input int data_w, input int keep_w,
                                        input int id_w, input int dest_w, input int user_w);
        return field_off(F_NUM, data_w, keep_w, id_w, dest_w, user_w);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DW x DEPTH storage array: synchronous write, asynchronous (fall-through) read.
// Write visible on rdata the cycle after the write edge; no backpressure, caller owns slot safety.
module sync_fifo_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_pkt_fifo.sv
// Single-clock AXIS FIFO with optional store-and-forward mode that discards bad or oversize frames.
// Latency: 1 cycle streaming, packet mode after tlast write; s_axis_tready low when full except while discarding.
module axis_sync_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int DATA_W         = 8,
    parameter int KEEP_W         = DATA_W / 8,
    parameter int ID_W           = 1,
    parameter int DEST_W         = 1,
    parameter int USER_W         = 1,
    parameter int PACKET_MODE    = 0,
    parameter int DROP_BAD_FRAME = 0,
    parameter int AF_TH          = DEPTH - 4,
    parameter int AE_TH          = 4
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,

    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic [KEEP_W-1:0]        s_axis_tstrb,
    input  logic [KEEP_W-1:0]        s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic [ID_W-1:0]          s_axis_tid,
    input  logic [DEST_W-1:0]        s_axis_tdest,
    input  logic [USER_W-1:0]        s_axis_tuser,

    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tstrb,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [ID_W-1:0]          m_axis_tid,
    output logic [DEST_W-1:0]        m_axis_tdest,
    output logic [USER_W-1:0]        m_axis_tuser,

    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     drop_bad,
    output logic                     drop_ovf,
    output logic                     pkt_commit
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PW     = packed_width(DATA_W, KEEP_W, ID_W, DEST_W, USER_W);
    localparam int O_DATA = field_off(F_TDATA, DATA_W, KEEP_W, ID_W, DEST_W, USER_W);
    localparam int O_STRB = field_off(F_TSTRB, DATA_W, KEEP_W, ID_W, DEST_W, USER_W);
    localparam int O_KEEP = field_off(F_TKEEP, DATA_W, KEEP_W, ID_W, DEST_W, USER_W);
    localparam int O_LAST = field_off(F_TLAST, DATA_W, KEEP_W, ID_W, DEST_W, USER_W);
    localparam int O_ID   = field_off(F_TID,   DATA_W, KEEP_W, ID_W, DEST_W, USER_W);
    localparam int O_DEST = field_off(F_TDEST, DATA_W, KEEP_W, ID_W, DEST_W, USER_W);
    localparam int O_USER = field_off(F_TUSER, DATA_W, KEEP_W, ID_W, DEST_W, USER_W);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W + 1)'(AF_TH);
    localparam logic [ADDR_W:0] AE_L    = (ADDR_W + 1)'(AE_TH);

    logic [ADDR_W:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0] commit_ptr, commit_nxt;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] uncommitted;
    wr_state_e       state, state_nxt;
    logic            full, wen, ren, mem_we;
    logic            commit_p, bad_p, ovf_p;
    logic [PW-1:0]   wdata, rdata, rd_beat;

    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign uncommitted = wr_ptr - commit_ptr;
    assign fill_level  = wr_ptr - rd_ptr;
    assign almost_full  = (fill_level >= AF_L);
    assign almost_empty = (fill_level <= AE_L);

    // Held low during reset so upstream never sees a handshake the FIFO ignores.
    assign s_axis_tready = ~axis_rst & ((state == ST_DROP) | ~full);
    assign m_axis_tvalid = (PACKET_MODE != 0) ? (commit_ptr != rd_ptr) : (wr_ptr != rd_ptr);
    assign wen = s_axis_tvalid & s_axis_tready;
    assign ren = m_axis_tvalid & m_axis_tready;

    always_comb begin
        wdata = '0;
        wdata[O_DATA +: DATA_W] = s_axis_tdata;
        wdata[O_STRB +: KEEP_W] = s_axis_tstrb;
        wdata[O_KEEP +: KEEP_W] = s_axis_tkeep;
        wdata[O_LAST]           = s_axis_tlast;
        wdata[O_ID   +: ID_W]   = s_axis_tid;
        wdata[O_DEST +: DEST_W] = s_axis_tdest;
        wdata[O_USER +: USER_W] = s_axis_tuser;
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        commit_nxt = commit_ptr;
        mem_we     = 1'b0;
        commit_p   = 1'b0;
        bad_p      = 1'b0;
        ovf_p      = 1'b0;
        if (PACKET_MODE == 0) begin
            mem_we = wen;
            if (wen) begin
                wr_ptr_nxt = wr_ptr + 1'b1;
            end
            commit_nxt = wr_ptr_nxt;
        end else begin
            case (state)
                ST_PASS: begin
                    if (wen) begin
                        if (s_axis_tlast && (DROP_BAD_FRAME != 0) && s_axis_tuser[0]) begin
                            wr_ptr_nxt = commit_ptr;
                            bad_p      = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + 1'b1;
                            if (s_axis_tlast) begin
                                commit_nxt = wr_ptr + 1'b1;
                                commit_p   = 1'b1;
                            end
                        end
                    end else if (full && (uncommitted == DEPTH_L)) begin
                        // The whole array holds one unfinished frame: it can never commit.
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = ST_DROP;
                        ovf_p      = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (wen && s_axis_tlast) begin
                        state_nxt = ST_PASS;
                    end
                end
                default: state_nxt = ST_PASS;
            endcase
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state      <= ST_PASS;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_commit <= 1'b0;
            drop_bad   <= 1'b0;
            drop_ovf   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_nxt;
            if (ren) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            pkt_commit <= commit_p;
            drop_bad   <= bad_p;
            drop_ovf   <= ovf_p;
        end
    end

    sync_fifo_ram #(
        .DW    (PW),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (axis_clk),
        .we    (mem_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Egress fields read as zero whenever no beat is offered.
    always_comb begin
        rd_beat       = m_axis_tvalid ? rdata : '0;
        m_axis_tdata  = rd_beat[O_DATA +: DATA_W];
        m_axis_tstrb  = rd_beat[O_STRB +: KEEP_W];
        m_axis_tkeep  = rd_beat[O_KEEP +: KEEP_W];
        m_axis_tlast  = rd_beat[O_LAST];
        m_axis_tid    = rd_beat[O_ID   +: ID_W];
        m_axis_tdest  = rd_beat[O_DEST +: DEST_W];
        m_axis_tuser  = rd_beat[O_USER +: USER_W];
    end

endmodule

// File: tb/tb_axis_sync_pkt_fifo.sv
// Streaming and packet-mode instances driven in turn, checked every cycle against a frame-level queue model.
module tb_axis_sync_pkt_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int KW    = 1;
    localparam int IW    = 2;
    localparam int DSW   = 2;
    localparam int UW    = 2;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int AF_TH = DEPTH - 4;
    localparam int AE_TH = 4;

    typedef struct packed {
        logic [UW-1:0]  user;
        logic [DSW-1:0] dest;
        logic [IW-1:0]  id;
        logic           last;
        logic [KW-1:0]  keep;
        logic [KW-1:0]  strb;
        logic [DW-1:0]  data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  sel;
    logic  s_vld;
    beat_t s_beat;
    logic  m_rdy;

    logic          rdy_a  [2];
    logic          vld_a  [2];
    beat_t         beat_a [2];
    logic [LW-1:0] fill_a [2];
    logic          af_a   [2];
    logic          ae_a   [2];
    logic          bad_a  [2];
    logic          ovf_a  [2];
    logic          com_a  [2];

    logic          o_rdy, o_vld, o_af, o_ae, o_bad, o_ovf, o_com;
    beat_t         o_beat;
    logic [LW-1:0] o_fill;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0]  d;
        logic [KW-1:0]  st, kp;
        logic           lst;
        logic [IW-1:0]  id;
        logic [DSW-1:0] ds;
        logic [UW-1:0]  us;

        axis_sync_pkt_fifo #(
            .DEPTH(DEPTH), .DATA_W(DW), .KEEP_W(KW), .ID_W(IW), .DEST_W(DSW), .USER_W(UW),
            .PACKET_MODE(g), .DROP_BAD_FRAME(g), .AF_TH(AF_TH), .AE_TH(AE_TH)
        ) u_dut (
            .axis_clk      (clk),
            .axis_rst      (rst),
            .s_axis_tvalid (s_vld && (int'(sel) == g)),
            .s_axis_tready (rdy_a[g]),
            .s_axis_tdata  (s_beat.data),
            .s_axis_tstrb  (s_beat.strb),
            .s_axis_tkeep  (s_beat.keep),
            .s_axis_tlast  (s_beat.last),
            .s_axis_tid    (s_beat.id),
            .s_axis_tdest  (s_beat.dest),
            .s_axis_tuser  (s_beat.user),
            .m_axis_tvalid (vld_a[g]),
            .m_axis_tready (m_rdy && (int'(sel) == g)),
            .m_axis_tdata  (d),
            .m_axis_tstrb  (st),
            .m_axis_tkeep  (kp),
            .m_axis_tlast  (lst),
            .m_axis_tid    (id),
            .m_axis_tdest  (ds),
            .m_axis_tuser  (us),
            .fill_level    (fill_a[g]),
            .almost_full   (af_a[g]),
            .almost_empty  (ae_a[g]),
            .drop_bad      (bad_a[g]),
            .drop_ovf      (ovf_a[g]),
            .pkt_commit    (com_a[g])
        );

        assign beat_a[g] = {us, ds, id, lst, kp, st, d};
    end

    always_comb begin
        o_rdy  = rdy_a[sel];
        o_vld  = vld_a[sel];
        o_beat = beat_a[sel];
        o_fill = fill_a[sel];
        o_af   = af_a[sel];
        o_ae   = ae_a[sel];
        o_bad  = bad_a[sel];
        o_ovf  = ovf_a[sel];
        o_com  = com_a[sel];
    end

    // Reference model: delivered-beat queue, the frame being collected, and pulses due next cycle.
    beat_t exp_q [$];
    beat_t part_q [$];
    beat_t src_q [$];
    bit    dropping, took, e_com, e_bad, e_ovf;
    int    vld_pct, rdy_pct;
    int    n_chk, n_err, n_out, n_com, n_bad, n_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_frame(input int len, input bit bad, input bit close);
        logic [31:0] r;
        beat_t b;
        for (int i = 0; i < len; i++) begin
            r = $urandom;
            b = r[$bits(beat_t)-1:0];
            b.last = close && (i == len - 1);
            if (b.last) b.user[0] = bad;
            src_q.push_back(b);
        end
    endtask

    task automatic accept(input beat_t b);
        if (!sel) begin
            exp_q.push_back(b);
        end else if (dropping) begin
            if (b.last) dropping = 1'b0;
        end else if (!b.last) begin
            part_q.push_back(b);
        end else if (b.user[0]) begin
            part_q.delete();
            e_bad = 1'b1;
        end else begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            exp_q.push_back(b);
            part_q.delete();
            e_com = 1'b1;
        end
    endtask

    task automatic cycle();
        int    fill_exp;
        beat_t b;
        if (took) begin
            src_q.delete(0);
            s_vld = 1'b0;
            took  = 1'b0;
        end
        if (!s_vld && src_q.size() != 0 && $urandom_range(99) < vld_pct) begin
            s_vld  = 1'b1;
            s_beat = src_q[0];
        end
        m_rdy = ($urandom_range(99) < rdy_pct);
        #1;
        fill_exp = exp_q.size() + part_q.size();
        check("fill_level",   o_fill, fill_exp);
        check("m_tvalid",     o_vld,  exp_q.size() != 0);
        check("s_tready",     o_rdy,  dropping || (fill_exp < DEPTH));
        check("almost_full",  o_af,   fill_exp >= AF_TH);
        check("almost_empty", o_ae,   fill_exp <= AE_TH);
        check("pkt_commit",   o_com,  e_com);
        check("drop_bad",     o_bad,  e_bad);
        check("drop_ovf",     o_ovf,  e_ovf);
        e_com = 1'b0;
        e_bad = 1'b0;
        e_ovf = 1'b0;
        if (o_com) n_com++;
        if (o_bad) n_bad++;
        if (o_ovf) n_ovf++;
        if (o_vld && m_rdy && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("m_beat", o_beat, b);
            n_out++;
        end
        took = s_vld && o_rdy;
        // A frame that fills the whole FIFO without tlast is discarded in the following cycle.
        if (sel && !dropping && part_q.size() == DEPTH) begin
            part_q.delete();
            dropping = 1'b1;
            e_ovf    = 1'b1;
        end else if (took) begin
            accept(s_beat);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((src_q.size() != 0 || s_vld || took || exp_q.size() != 0 || part_q.size() != 0)
               && k < bound) begin
            cycle();
            k++;
        end
        check("idle_timeout", k < bound, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int c0, b0, v0, o0, k;
        rst = 1'b1; sel = 1'b0; s_vld = 1'b0; s_beat = '0; m_rdy = 1'b0;
        took = 1'b0; dropping = 1'b0; e_com = 1'b0; e_bad = 1'b0; e_ovf = 1'b0;
        n_chk = 0; n_err = 0; n_out = 0; n_com = 0; n_bad = 0; n_ovf = 0;
        vld_pct = 100; rdy_pct = 100;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #1;
            check("rst_tvalid",       o_vld,  0);
            check("rst_fill",         o_fill, 0);
            check("rst_almost_empty", o_ae,   1);
            check("rst_almost_full",  o_af,   0);
            check("rst_tready",       o_rdy,  0);
            check("rst_pulses",       {o_com, o_bad, o_ovf}, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Streaming: fill to full with egress stalled, then read and write together.
        add_frame(10, 1'b0, 1'b1);
        vld_pct = 100; rdy_pct = 0;
        repeat (8) cycle();
        #1;
        check("full_fill",   o_fill, DEPTH);
        check("full_tready", o_rdy,  0);
        check("full_af",     o_af,   1);
        add_frame(10, 1'b0, 1'b1);
        rdy_pct = 100;
        repeat (8) cycle();
        #1;
        check("rdwr_fill_steady", o_fill, DEPTH - 1);
        wait_idle(200);
        check("stream_beats_out", n_out, 20);

        // Packet mode: a good frame, a bad frame followed by a good one, an oversize frame.
        sel = 1'b1;
        c0 = n_com; o0 = n_out;
        add_frame(3, 1'b0, 1'b1);
        wait_idle(100);
        check("good_commit_cnt", n_com - c0, 1);
        check("good_beats_out",  n_out - o0, 3);

        b0 = n_bad; o0 = n_out;
        add_frame(4, 1'b1, 1'b1);
        add_frame(2, 1'b0, 1'b1);
        wait_idle(100);
        #1;
        check("bad_drop_cnt",   n_bad - b0, 1);
        check("bad_beats_out",  n_out - o0, 2);
        check("bad_fill_final", o_fill, 0);

        v0 = n_ovf; c0 = n_com; o0 = n_out;
        add_frame(12, 1'b0, 1'b1);
        add_frame(2, 1'b0, 1'b1);
        wait_idle(100);
        check("ovf_drop_cnt",   n_ovf - v0, 1);
        check("ovf_commit_cnt", n_com - c0, 1);
        check("ovf_beats_out",  n_out - o0, 2);

        // Reset with one committed frame and an open frame stored.
        rdy_pct = 0;
        add_frame(2, 1'b0, 1'b1);
        add_frame(3, 1'b0, 1'b0);
        k = 0;
        while ((src_q.size() != 0 || took) && k < 50) begin
            cycle();
            k++;
        end
        check("prerst_timeout", k < 50, 1);
        #1;
        check("prerst_fill",   o_fill, 5);
        check("prerst_tvalid", o_vld,  1);
        rst = 1'b1;
        #1;
        check("midrst_fill",         o_fill, 0);
        check("midrst_tvalid",       o_vld,  0);
        check("midrst_almost_empty", o_ae,   1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); part_q.delete(); src_q.delete();
        s_vld = 1'b0; took = 1'b0; dropping = 1'b0;
        e_com = 1'b0; e_bad = 1'b0; e_ovf = 1'b0;
        c0 = n_com; o0 = n_out;
        rdy_pct = 100;
        add_frame(3, 1'b0, 1'b1);
        wait_idle(100);
        check("postrst_commit_cnt", n_com - c0, 1);
        check("postrst_beats_out",  n_out - o0, 3);

        // Randomised traffic in both modes.
        for (int m = 0; m < 2; m++) begin
            sel = 1'(m);
            for (int c = 0; c < 5; c++) begin
                vld_pct = $urandom_range(30, 100);
                rdy_pct = $urandom_range(30, 100);
                for (int f = 0; f < 5; f++) begin
                    add_frame($urandom_range(1, 12), $urandom_range(3) == 0, 1'b1);
                end
                wait_idle(2000);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
